onehot_grant_decoder: RTL and testbench

Sequential 3-to-8 decoder sitting on the consumer side of the priority encoder: it accepts an encoded index over a valid/ready handshake and drives the matching one-hot grant line. The line stays up for a minimum hold time and until the downstream acknowledges it. An enable gates the whole block, and a drop counter records codes discarded while disabled or aborted. It turns the encoder's 3-bit winner index back into a registered, handshaken one-hot select for the 8 request sources.

---
 rtl/grant_dec_pkg.sv | 29 ++
 rtl/grant_hold_timer.sv | 37 +++
 rtl/onehot_grant_decoder.sv | 144 ++++++++++++++
 tb/tb_onehot_grant_decoder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/grant_dec_pkg.sv
// rtl/grant_dec_pkg.sv - shared types and constants for the one-hot grant decoder
//
// Purpose: state encoding, line/code/counter widths and the code-to-one-hot
//          helper shared by onehot_grant_decoder and grant_hold_timer.
// Ports:   none (package).

package grant_dec_pkg;

   localparam int N_LINES = 8;
   localparam int CODE_W  = 3;
   localparam int HOLD_W  = 8;
   localparam int DROP_W  = 8;

   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRIVE    = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   function automatic logic [N_LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
      logic [N_LINES-1:0] oh;
      oh       = '0;
      oh[code] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/grant_hold_timer.sv
// rtl/grant_hold_timer.sv - loadable down-counter enforcing the minimum grant hold time
//
// Purpose: counts the remaining hold cycles of an active grant.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   load      in   load load_val (has priority over decrement)
//   load_val  in   value loaded on load
//   dec_en    in   decrement by one; the counter stops at zero
//   hold_cnt  out  current count
//   zero      out  hold_cnt == 0

module grant_hold_timer
   import grant_dec_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [HOLD_W-1:0] load_val,
   input  logic              dec_en,
   output logic [HOLD_W-1:0] hold_cnt,
   output logic              zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (load) begin
         hold_cnt <= load_val;
      end else if (dec_en && (hold_cnt != '0)) begin
         hold_cnt <= hold_cnt - 1'b1;
      end
   end

   assign zero = (hold_cnt == '0);

endmodule

// File: rtl/onehot_grant_decoder.sv
// rtl/onehot_grant_decoder.sv - handshaken 3-to-8 decoder driving a held, acknowledged one-hot grant
//
// Purpose: accepts an encoded winner index over valid/ready and drives the
//          matching one-hot grant line for at least HOLD_CYCLES cycles and
//          until acknowledged. Codes taken while disabled, and grants aborted
//          by en falling, are counted in a saturating drop counter.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   block enable
//   in_valid  in   code is valid
//   in_ready  out  code can be accepted this cycle (combinational)
//   code      in   encoded index 0..7
//   y         out  registered one-hot grant, zero when idle
//   y_valid   out  grant active
//   y_ack     in   downstream acknowledge
//   drop_cnt  out  saturating count of discarded/aborted codes

module onehot_grant_decoder
   import grant_dec_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CODE_W-1:0]  code,
   output logic [N_LINES-1:0] y,
   output logic               y_valid,
   input  logic               y_ack,
   output logic [DROP_W-1:0]  drop_cnt
);

   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

   state_t             state_q, state_d;
   logic [N_LINES-1:0] y_d;
   logic               y_valid_d;
   logic               drop_inc;
   logic               timer_load;
   logic               timer_dec;
   logic [HOLD_W-1:0]  hold_cnt;
   logic               hold_zero;
   logic               completion;
   logic               accept;

   grant_hold_timer u_hold_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (HOLD_RELOAD),
      .dec_en   (timer_dec),
      .hold_cnt (hold_cnt),
      .zero     (hold_zero)
   );

   // Completion requires en: a disable in DRIVE/WAIT_ACK is an abort, and an
   // abort must win over a same-cycle acknowledge.
   assign completion = en && y_ack &&
                       ((state_q == WAIT_ACK) || ((state_q == DRIVE) && hold_zero));
   assign in_ready   = (state_q == IDLE) || completion;
   assign accept     = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      y_d        = y;
      y_valid_d  = y_valid;
      drop_inc   = 1'b0;
      timer_load = 1'b0;
      timer_dec  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (en) begin
                  y_d        = code_to_onehot(code);
                  y_valid_d  = 1'b1;
                  timer_load = 1'b1;
                  state_d    = DRIVE;
               end else begin
                  drop_inc = 1'b1;
               end
            end
         end

         DRIVE, WAIT_ACK: begin
            if (!en) begin
               y_d       = '0;
               y_valid_d = 1'b0;
               drop_inc  = 1'b1;
               state_d   = IDLE;
            end else if (completion) begin
               // Back-to-back: a code accepted on the completing cycle is
               // loaded straight over the old grant, so y_valid never drops.
               if (accept) begin
                  y_d        = code_to_onehot(code);
                  y_valid_d  = 1'b1;
                  timer_load = 1'b1;
                  state_d    = DRIVE;
               end else begin
                  y_d       = '0;
                  y_valid_d = 1'b0;
                  state_d   = IDLE;
               end
            end else if (state_q == DRIVE) begin
               // Early acks are simply not acted upon; nothing latches them.
               timer_dec = (hold_cnt != '0);
               if (hold_zero) begin
                  state_d = WAIT_ACK;
               end
            end
         end

         default: begin
            y_d       = '0;
            y_valid_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         y       <= '0;
         y_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         y       <= y_d;
         y_valid <= y_valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop_inc && (drop_cnt != DROP_MAX)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// tb/tb_onehot_grant_decoder.sv - self-checking directed bench for onehot_grant_decoder

module tb_onehot_grant_decoder;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] code;
   logic [7:0] y;
   logic       y_valid;
   logic       y_ack;
   logic [7:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   onehot_grant_decoder #(.HOLD_CYCLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .code     (code),
      .y        (y),
      .y_valid  (y_valid),
      .y_ack    (y_ack),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; code = 3'd0; y_ack = 1'b0;
      #3;
      checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", y); end
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
      step();
      step();
      rst_n = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic_grant();
      en = 1'b1; in_valid = 1'b1; code = 3'd5; y_ack = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (y !== 8'h20 || y_valid !== 1'b1) begin errors++; $display("FAIL basic_y cyc=%0d got=%h/%b exp=20/1", i, y, y_valid); end
         if (i == 0) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_hold got=%b exp=0", in_ready); end
         end
         if (i == 3) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_complete got=%b exp=1", in_ready); end
         end
         step();
      end
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL basic_end got=%h/%b exp=00/0", y, y_valid); end
      y_ack = 1'b0;
   endtask

   task automatic test_late_ack();
      en = 1'b1; in_valid = 1'b1; code = 3'd0; y_ack = 1'b0;
      step();
      in_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         checks++; if (y !== 8'h01 || y_valid !== 1'b1) begin errors++; $display("FAIL late_y cyc=%0d got=%h/%b exp=01/1", c, y, y_valid); end
         if (c == 5) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL late_ready_wait got=%b exp=0", in_ready); end
         end
         y_ack = (c == 2) || (c == 7);
         step();
      end
      y_ack = 1'b0;
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL late_end got=%h/%b exp=00/0", y, y_valid); end
   endtask

   task automatic test_back_to_back();
      en = 1'b1; in_valid = 1'b1; code = 3'd7; y_ack = 1'b1;
      step();
      code = 3'd2;
      for (int i = 0; i < 4; i++) begin
         checks++; if (y !== 8'h80 || y_valid !== 1'b1) begin errors++; $display("FAIL b2b_first cyc=%0d got=%h/%b exp=80/1", i, y, y_valid); end
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (y !== 8'h04 || y_valid !== 1'b1) begin errors++; $display("FAIL b2b_second cyc=%0d got=%h/%b exp=04/1", i, y, y_valid); end
         step();
      end
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%h/%b exp=00/0", y, y_valid); end
      y_ack = 1'b0;
   endtask

   task automatic test_disable_abort();
      en = 1'b0; in_valid = 1'b1; code = 3'd3; y_ack = 1'b0;
      step();
      in_valid = 1'b0;
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL dis_y got=%h/%b exp=00/0", y, y_valid); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL dis_drop got=%0d exp=1", drop_cnt); end

      en = 1'b1; in_valid = 1'b1; code = 3'd6; y_ack = 1'b0;
      step();
      in_valid = 1'b0;
      checks++; if (y !== 8'h40) begin errors++; $display("FAIL abort_pre got=%h exp=40", y); end
      step();
      en = 1'b0;
      y_ack = 1'b1;
      step();
      y_ack = 1'b0;
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL abort_y got=%h/%b exp=00/0", y, y_valid); end
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL abort_drop got=%0d exp=2", drop_cnt); end

      in_valid = 1'b1;
      for (int i = 0; i < 252; i++) step();
      checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_pre got=%0d exp=254", drop_cnt); end
      for (int i = 0; i < 48; i++) step();
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", drop_cnt); end
      in_valid = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_async_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      en = 1'b1; in_valid = 1'b1; code = 3'd4; y_ack = 1'b0;
      step();
      in_valid = 1'b0;
      checks++; if (y !== 8'h10) begin errors++; $display("FAIL arst_pre got=%h exp=10", y); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL arst_y got=%h/%b exp=00/0", y, y_valid); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL arst_drop got=%0d exp=0", drop_cnt); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1 || y !== 8'h00) begin errors++; $display("FAIL arst_idle got=%b/%h exp=1/00", in_ready, y); end
   endtask

   initial begin
      test_reset();
      test_basic_grant();
      test_late_ack();
      test_back_to_back();
      test_disable_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
